// File: rtl/ifetch_unit.sv
// Instruction fetch front end: one outstanding memory request feeding a small
// FIFO of {PC, instruction} pairs. Taken jumps and branches flush it and redirect fetch.
module ifetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              Clk,
    input  logic              Rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       Inst,
    output logic [ADDR_W-1:0] PC,
    input  logic              Jump,
    input  logic              Branch,
    input  logic              Z
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT    = 2'd1;
    localparam logic [1:0] ST_DISCARD = 2'd2;

    localparam logic [ADDR_W-1:0] HI_MASK   = ~ADDR_W'(28'hFFF_FFFF);
    localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);

    logic [1:0]        state;
    logic [ADDR_W-1:0] fpc;
    logic [31:0]       inst_buf [DEPTH];
    logic [ADDR_W-1:0] pc_buf   [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;

    logic              accept;
    logic              redirect;
    logic              push;
    logic              issue;
    logic [CNT_W-1:0]  occ_after_pop;
    logic [ADDR_W-1:0] target;

    // Region bits above bit 27 come from the current PC; the rest is the word index.
    function automatic logic [ADDR_W-1:0] jump_target(input logic [ADDR_W-1:0] pc,
                                                      input logic [25:0]       idx);
        return (pc & HI_MASK) | ADDR_W'({idx, 2'b00});
    endfunction

    function automatic logic [ADDR_W-1:0] branch_target(input logic [ADDR_W-1:0] pc,
                                                        input logic [15:0]       imm);
        logic signed [ADDR_W-1:0] off;
        off = {{(ADDR_W-18){imm[15]}}, imm, 2'b00};
        return pc + WORD_STEP + $unsigned(off);
    endfunction

    assign inst_valid    = (count != '0);
    assign Inst          = inst_buf[rd_ptr];
    assign PC            = pc_buf[rd_ptr];
    assign accept        = inst_valid & inst_ready;
    assign redirect      = accept & (Jump | (Branch & Z));
    assign target        = Jump ? jump_target(PC, Inst[25:0]) : branch_target(PC, Inst[15:0]);
    assign occ_after_pop = count - CNT_W'(accept);
    assign push          = (state == ST_WAIT) & imem_ack & ~redirect;
    // Space is judged after this cycle's pop, so a full buffer being drained can refill at once.
    assign issue         = (state == ST_IDLE) & ~redirect & (occ_after_pop < CNT_W'(DEPTH));

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= ST_IDLE;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
            fpc       <= RESET_PC;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
        end else begin
            if (redirect) begin
                fpc    <= target;
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                    fpc    <= fpc + WORD_STEP;
                end
                if (accept) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                count <= occ_after_pop + CNT_W'(push);
            end

            case (state)
                ST_IDLE: begin
                    if (issue) begin
                        imem_req  <= 1'b1;
                        imem_addr <= fpc;
                        state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_ack) begin
                        imem_req <= 1'b0;
                        state    <= ST_IDLE;
                    end else if (redirect) begin
                        state <= ST_DISCARD;
                    end
                end
                ST_DISCARD: begin
                    // The request stays on the bus until memory answers; its word is thrown away.
                    if (imem_ack) begin
                        imem_req <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                default: begin
                    imem_req <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (push) begin
            inst_buf[wr_ptr] <= imem_rdata;
            pc_buf[wr_ptr]   <= fpc;
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: three configurations, each with a
// fixed-latency instruction memory responder.
module tb_ifetch_unit;

    localparam int LAT_A = 1;
    localparam int LAT_B = 3;
    localparam int LAT_C = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Instance A: ADDR_W=32, DEPTH=2, RESET_PC=0
    logic        rst_a, a_req, a_ack, a_valid, a_ready, a_jump, a_branch, a_z;
    logic [31:0] a_addr, a_rdata, a_inst, a_pc;
    logic        a_man, a_man_ack;
    logic [31:0] a_man_rdata;
    logic        a_auto_ack   = 1'b0;
    logic [31:0] a_auto_rdata = '0;
    int          a_cnt        = 0;

    // Instance B: ADDR_W=30, DEPTH=4, RESET_PC just below the wrap point
    logic        rst_b, b_req, b_ack, b_valid, b_ready, b_jump, b_branch, b_z;
    logic [29:0] b_addr, b_pc;
    logic [31:0] b_rdata, b_inst;
    int          b_cnt = 0;

    // Instance C: ADDR_W=32, DEPTH=2, RESET_PC=0x1000_0040
    logic        rst_c, c_req, c_ack, c_valid, c_ready, c_jump, c_branch, c_z;
    logic [31:0] c_addr, c_rdata, c_inst, c_pc;
    int          c_cnt = 0;

    ifetch_unit #(.ADDR_W(32), .DEPTH(2), .RESET_PC(32'h0)) dut_a (
        .Clk(clk), .Rst(rst_a), .imem_req(a_req), .imem_addr(a_addr),
        .imem_ack(a_ack), .imem_rdata(a_rdata), .inst_valid(a_valid),
        .inst_ready(a_ready), .Inst(a_inst), .PC(a_pc),
        .Jump(a_jump), .Branch(a_branch), .Z(a_z)
    );

    ifetch_unit #(.ADDR_W(30), .DEPTH(4), .RESET_PC(30'h3FFF_FFF8)) dut_b (
        .Clk(clk), .Rst(rst_b), .imem_req(b_req), .imem_addr(b_addr),
        .imem_ack(b_ack), .imem_rdata(b_rdata), .inst_valid(b_valid),
        .inst_ready(b_ready), .Inst(b_inst), .PC(b_pc),
        .Jump(b_jump), .Branch(b_branch), .Z(b_z)
    );

    ifetch_unit #(.ADDR_W(32), .DEPTH(2), .RESET_PC(32'h1000_0040)) dut_c (
        .Clk(clk), .Rst(rst_c), .imem_req(c_req), .imem_addr(c_addr),
        .imem_ack(c_ack), .imem_rdata(c_rdata), .inst_valid(c_valid),
        .inst_ready(c_ready), .Inst(c_inst), .PC(c_pc),
        .Jump(c_jump), .Branch(c_branch), .Z(c_z)
    );

    function automatic logic [31:0] word_a(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'h1000_FFFE;
        return {8'hA4, a[23:0]};
    endfunction

    function automatic logic [31:0] word_b(input logic [29:0] a);
        return {2'b10, a};
    endfunction

    function automatic logic [31:0] word_c(input logic [31:0] a);
        if (a == 32'h1000_0040) return 32'h0800_0010;
        return {8'hA4, a[23:0]};
    endfunction

    // Memory responders: ack arrives in the LAT-th cycle that a request is held high.
    always @(negedge clk) begin
        a_auto_ack = 1'b0;
        if (a_req) begin
            a_cnt = a_cnt + 1;
            if (a_cnt >= LAT_A) begin
                a_auto_ack   = 1'b1;
                a_auto_rdata = word_a(a_addr);
                a_cnt        = 0;
            end
        end else begin
            a_cnt = 0;
        end
    end

    assign a_ack   = a_man ? a_man_ack   : a_auto_ack;
    assign a_rdata = a_man ? a_man_rdata : a_auto_rdata;

    always @(negedge clk) begin
        b_ack = 1'b0;
        if (b_req) begin
            b_cnt = b_cnt + 1;
            if (b_cnt >= LAT_B) begin
                b_ack   = 1'b1;
                b_rdata = word_b(b_addr);
                b_cnt   = 0;
            end
        end else begin
            b_cnt = 0;
        end
    end

    always @(negedge clk) begin
        c_ack = 1'b0;
        if (c_req) begin
            c_cnt = c_cnt + 1;
            if (c_cnt >= LAT_C) begin
                c_ack   = 1'b1;
                c_rdata = word_c(c_addr);
                c_cnt   = 0;
            end
        end else begin
            c_cnt = 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic wait_a(input string tag);
        for (int i = 0; i < 40 && a_valid !== 1'b1; i++) step();
        chk1(tag, a_valid, 1'b1);
    endtask

    task automatic wait_b(input string tag);
        for (int i = 0; i < 40 && b_valid !== 1'b1; i++) step();
        chk1(tag, b_valid, 1'b1);
    endtask

    task automatic wait_c(input string tag);
        for (int i = 0; i < 40 && c_valid !== 1'b1; i++) step();
        chk1(tag, c_valid, 1'b1);
    endtask

    initial begin
        rst_a = 1'b1; a_ready = 1'b0; a_jump = 1'b0; a_branch = 1'b0; a_z = 1'b0;
        a_man = 1'b0; a_man_ack = 1'b0; a_man_rdata = '0;
        rst_b = 1'b1; b_ready = 1'b0; b_jump = 1'b0; b_branch = 1'b0; b_z = 1'b0;
        rst_c = 1'b1; c_ready = 1'b0; c_jump = 1'b0; c_branch = 1'b0; c_z = 1'b0;
        step();
        step();

        // ---------------- Instance A ----------------
        chk1("a_reset_valid", a_valid, 1'b0);
        chk1("a_reset_req", a_req, 1'b0);
        chk("a_reset_addr", a_addr, 32'h0);

        rst_a   = 1'b0;
        a_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_a("a_seq_wait");
            chk("a_seq_pc", a_pc, 32'(k * 4));
            chk("a_seq_inst", a_inst, word_a(32'(k * 4)));
            step();
        end

        // Decode stalls: buffer fills to DEPTH and fetching stops.
        a_ready = 1'b0;
        repeat (5) step();
        chk("a_stall_pc_mid", a_pc, 32'h10);
        repeat (5) step();
        chk1("a_stall_valid", a_valid, 1'b1);
        chk1("a_stall_req_low", a_req, 1'b0);
        chk("a_stall_pc_end", a_pc, 32'h10);
        chk("a_stall_inst_end", a_inst, word_a(32'h10));

        a_ready = 1'b1;
        for (int p = 'h10; p < 'h40; p += 4) begin
            wait_a("a_drain_wait");
            chk("a_drain_pc", a_pc, 32'(p));
            chk("a_drain_inst", a_inst, word_a(32'(p)));
            step();
        end

        // Jump at 0x40 -> 0x100, everything behind it is flushed.
        wait_a("a_jump_wait");
        chk("a_jump_src_pc", a_pc, 32'h40);
        a_jump = 1'b1;
        step();
        a_jump = 1'b0;
        chk1("a_jump_flush", a_valid, 1'b0);
        wait_a("a_jump_tgt_wait");
        chk("a_jump_tgt_pc", a_pc, 32'h100);
        chk("a_jump_tgt_inst", a_inst, 32'h1000_FFFE);

        // Taken branch, offset -2 words: 0x100 + 4 - 8.
        a_branch = 1'b1; a_z = 1'b1;
        step();
        a_branch = 1'b0; a_z = 1'b0;
        chk1("a_br_flush", a_valid, 1'b0);
        wait_a("a_br_wait");
        chk("a_br_tgt_pc", a_pc, 32'hFC);
        chk("a_br_tgt_inst", a_inst, word_a(32'hFC));

        // Untaken branch: sequential fetch continues.
        a_branch = 1'b1; a_z = 1'b0;
        step();
        a_branch = 1'b0;
        wait_a("a_nbr_wait");
        chk("a_nbr_pc", a_pc, 32'h100);

        // Reset while a request is outstanding, then a stale ack.
        a_man = 1'b1;
        for (int i = 0; i < 20 && a_req !== 1'b1; i++) step();
        chk1("a_pre_rst_req", a_req, 1'b1);
        rst_a = 1'b1;
        step();
        step();
        chk1("a_rst_req", a_req, 1'b0);
        chk1("a_rst_valid", a_valid, 1'b0);
        chk("a_rst_addr", a_addr, 32'h0);
        rst_a       = 1'b0;
        a_man_ack   = 1'b1;
        a_man_rdata = 32'hDEAD_BEEF;
        step();
        a_man_ack = 1'b0;
        a_man     = 1'b0;
        chk1("a_stale_valid", a_valid, 1'b0);
        chk1("a_post_rst_req", a_req, 1'b1);
        chk("a_post_rst_addr", a_addr, 32'h0);
        wait_a("a_post_rst_wait");
        chk("a_post_rst_pc", a_pc, 32'h0);
        chk("a_post_rst_inst", a_inst, word_a(32'h0));

        // ---------------- Instance B ----------------
        chk1("b_reset_valid", b_valid, 1'b0);
        chk1("b_reset_req", b_req, 1'b0);
        chk("b_reset_addr", {2'b00, b_addr}, 32'h3FFF_FFF8);
        rst_b = 1'b0;
        repeat (30) step();
        chk1("b_full_valid", b_valid, 1'b1);
        chk1("b_full_req_low", b_req, 1'b0);
        chk("b_full_pc", {2'b00, b_pc}, 32'h3FFF_FFF8);
        chk("b_full_inst", b_inst, 32'hBFFF_FFF8);
        // Four buffered entries drain back to back, across the address wrap.
        b_ready = 1'b1;
        step();
        chk1("b_drain1_valid", b_valid, 1'b1);
        chk("b_drain1_pc", {2'b00, b_pc}, 32'h3FFF_FFFC);
        step();
        chk1("b_drain2_valid", b_valid, 1'b1);
        chk("b_drain2_pc", {2'b00, b_pc}, 32'h0);
        chk("b_drain2_inst", b_inst, 32'h8000_0000);
        step();
        chk1("b_drain3_valid", b_valid, 1'b1);
        chk("b_drain3_pc", {2'b00, b_pc}, 32'h4);
        step();
        wait_b("b_next_wait");
        chk("b_next_pc", {2'b00, b_pc}, 32'h8);
        chk("b_next_inst", b_inst, 32'h8000_0008);

        // ---------------- Instance C ----------------
        chk("c_reset_addr", c_addr, 32'h1000_0040);
        rst_c = 1'b0;
        wait_c("c_first_wait");
        chk("c_first_pc", c_pc, 32'h1000_0040);
        chk("c_first_inst", c_inst, 32'h0800_0010);
        step();
        chk1("c_out_req", c_req, 1'b1);
        chk("c_out_addr", c_addr, 32'h1000_0044);
        // Jump accepted while the 0x..44 fetch is still outstanding.
        c_ready = 1'b1; c_jump = 1'b1;
        step();
        c_jump = 1'b0;
        chk1("c_disc_valid", c_valid, 1'b0);
        chk1("c_disc_req", c_req, 1'b1);
        chk("c_disc_addr", c_addr, 32'h1000_0044);
        wait_c("c_disc_tgt_wait");
        chk("c_disc_tgt_pc", c_pc, 32'h1000_0040);
        chk("c_disc_tgt_inst", c_inst, 32'h0800_0010);

        // Jump and taken branch together: jump wins.
        c_jump = 1'b1; c_branch = 1'b1; c_z = 1'b1;
        step();
        c_jump = 1'b0; c_branch = 1'b0; c_z = 1'b0;
        wait_c("c_prio_wait");
        chk("c_prio_pc", c_pc, 32'h1000_0040);

        // Branch alone: 0x1000_0044 + (0x10 << 2).
        c_branch = 1'b1; c_z = 1'b1;
        step();
        c_branch = 1'b0; c_z = 1'b0;
        wait_c("c_br_wait");
        chk("c_br_pc", c_pc, 32'h1000_0084);
        chk("c_br_inst", c_inst, 32'hA400_0084);

        // Jump keeps the region bits: {0x1, 0x84 << 2}.
        c_jump = 1'b1;
        step();
        c_jump = 1'b0;
        wait_c("c_jmp2_wait");
        chk("c_jmp2_pc", c_pc, 32'h1000_0210);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
